// File: rtl/edge_pkg.sv
// Shared types and sizing helpers for the edge-detection frame writer.
package edge_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_e;

    localparam int unsigned IMG_W_DEF = 512;
    localparam int unsigned IMG_H_DEF = 512;

    // Bits needed to hold any value in 0..max_val (never less than one).
    function automatic int unsigned width_for(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/edge_write_controller_if.sv
// Pixel-in / SRAM-write-out bundle between the frame writer and its surroundings.
interface edge_write_controller_if #(
    parameter int unsigned ADDR_W = 18,
    parameter int unsigned DATA_W = 8
);
    logic              frame_start;
    logic [ADDR_W-1:0] base_addr;
    logic              gray_mode;
    logic              in_valid;
    logic              in_ready;
    logic              edge_bit;
    logic [DATA_W-1:0] gray_data;
    logic              sram_ready;
    logic              sram_we;
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_data;
    logic              busy;
    logic              frame_done;

    modport master (
        output frame_start, base_addr, gray_mode, in_valid, edge_bit, gray_data, sram_ready,
        input  in_ready, sram_we, sram_addr, sram_data, busy, frame_done
    );

    modport slave (
        input  frame_start, base_addr, gray_mode, in_valid, edge_bit, gray_data, sram_ready,
        output in_ready, sram_we, sram_addr, sram_data, busy, frame_done
    );
endinterface

// File: rtl/scan_addr_gen.sv
// Raster/serpentine scan position, pixel count and SRAM address for one frame.
module scan_addr_gen
    import edge_pkg::*;
#(
    parameter int unsigned IMG_W      = IMG_W_DEF,
    parameter int unsigned IMG_H      = IMG_H_DEF,
    parameter int unsigned ADDR_W     = 18,
    parameter int unsigned SERPENTINE = 1
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              i_clear,
    input  logic              i_advance,
    input  logic [ADDR_W-1:0] i_base,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_last
);
    localparam int unsigned NPIX = IMG_W * IMG_H;
    localparam int unsigned XW   = width_for(IMG_W - 1);
    localparam int unsigned YW   = width_for(IMG_H - 1);
    localparam int unsigned CW   = width_for(NPIX);
    localparam int unsigned SW   = ADDR_W + CW;

    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;
    logic          r_dir;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_x   <= '0;
            r_y   <= '0;
            r_dir <= 1'b0;
            r_cnt <= '0;
        end else if (i_clear) begin
            r_x   <= '0;
            r_y   <= '0;
            r_dir <= 1'b0;
            r_cnt <= '0;
        end else if (i_advance) begin
            r_cnt <= r_cnt + CW'(1);
            if (!r_dir) begin
                if (r_x < XW'(IMG_W - 1)) begin
                    r_x <= r_x + XW'(1);
                end else begin
                    r_y <= r_y + YW'(1);
                    if (SERPENTINE != 0) r_dir <= 1'b1;
                    else                 r_x   <= '0;
                end
            end else begin
                if (r_x != '0) begin
                    r_x <= r_x - XW'(1);
                end else begin
                    r_y   <= r_y + YW'(1);
                    r_dir <= 1'b0;
                end
            end
        end
    end

    // Wide sum then truncate, so frames crossing the top of memory wrap to zero.
    assign o_addr = ADDR_W'(SW'(i_base) + SW'(r_y) * SW'(IMG_W) + SW'(r_x));
    assign o_last = (r_cnt == CW'(NPIX - 1));

endmodule

// File: rtl/edge_write_controller.sv
// Frame writer: accepts one pixel per handshake and drives a registered SRAM write port.
module edge_write_controller
    import edge_pkg::*;
#(
    parameter int unsigned IMG_W      = IMG_W_DEF,
    parameter int unsigned IMG_H      = IMG_H_DEF,
    parameter int unsigned ADDR_W     = 18,
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned SERPENTINE = 1
) (
    input logic                    clk,
    input logic                    n_rst,
    edge_write_controller_if.slave bus
);
    state_e            r_state;
    state_e            w_state_d;
    logic              r_gray;
    logic [ADDR_W-1:0] r_base;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;
    logic              r_done;
    logic              w_done_d;
    logic              w_in_ready;
    logic              w_accept;
    logic              w_start;
    logic [ADDR_W-1:0] w_addr;
    logic              w_last;

    assign w_in_ready = (r_state == RUN) & (~r_we | bus.sram_ready);
    assign w_accept   = bus.in_valid & w_in_ready;
    // A start landing on the frame_done cycle is dropped; the next frame needs a later pulse.
    assign w_start    = (r_state == IDLE) & bus.frame_start & ~r_done;

    scan_addr_gen #(
        .IMG_W      (IMG_W),
        .IMG_H      (IMG_H),
        .ADDR_W     (ADDR_W),
        .SERPENTINE (SERPENTINE)
    ) u_scan (
        .clk       (clk),
        .n_rst     (n_rst),
        .i_clear   (w_start),
        .i_advance (w_accept),
        .i_base    (r_base),
        .o_addr    (w_addr),
        .o_last    (w_last)
    );

    always_comb begin
        w_state_d = r_state;
        w_done_d  = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_start) w_state_d = RUN;
            end
            RUN: begin
                if (w_accept && w_last) w_state_d = FLUSH;
            end
            FLUSH: begin
                if (!r_we || bus.sram_ready) begin
                    w_state_d = IDLE;
                    w_done_d  = 1'b1;
                end
            end
            default: w_state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= IDLE;
            r_done  <= 1'b0;
            r_gray  <= 1'b0;
            r_base  <= '0;
        end else begin
            r_state <= w_state_d;
            r_done  <= w_done_d;
            if (w_start) begin
                r_gray <= bus.gray_mode;
                r_base <= bus.base_addr;
            end
        end
    end

    // Output register holds under back-pressure; addr/data keep their last value when idle.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_we   <= 1'b0;
            r_addr <= '0;
            r_data <= '0;
        end else if (w_accept) begin
            r_we   <= 1'b1;
            r_addr <= w_addr;
            r_data <= r_gray ? bus.gray_data : {DATA_W{bus.edge_bit}};
        end else if (bus.sram_ready) begin
            r_we   <= 1'b0;
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.sram_we    = r_we;
    assign bus.sram_addr  = r_addr;
    assign bus.sram_data  = r_data;
    assign bus.busy       = (r_state != IDLE);
    assign bus.frame_done = r_done;

endmodule

// File: tb/tb_edge_write_controller.sv
// Randomised bench: serpentine and raster writers checked cycle-by-cycle against a pixel-index model.
module tb_edge_write_controller;
    localparam int unsigned W  = 4;
    localparam int unsigned H  = 3;
    localparam int unsigned AW = 18;
    localparam int unsigned DW = 8;
    localparam int unsigned N  = W * H;

    logic          clk = 1'b0;
    logic          n_rst = 1'b0;
    logic          frame_start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic          gray_mode = 1'b0;
    logic          in_valid = 1'b0;
    logic          edge_bit = 1'b0;
    logic [DW-1:0] gray_data = '0;
    logic          sram_ready = 1'b0;

    always #5 clk = ~clk;

    edge_write_controller_if #(.ADDR_W(AW), .DATA_W(DW)) bus_s ();
    edge_write_controller_if #(.ADDR_W(AW), .DATA_W(DW)) bus_r ();

    assign bus_s.frame_start = frame_start;
    assign bus_s.base_addr   = base_addr;
    assign bus_s.gray_mode   = gray_mode;
    assign bus_s.in_valid    = in_valid;
    assign bus_s.edge_bit    = edge_bit;
    assign bus_s.gray_data   = gray_data;
    assign bus_s.sram_ready  = sram_ready;
    assign bus_r.frame_start = frame_start;
    assign bus_r.base_addr   = base_addr;
    assign bus_r.gray_mode   = gray_mode;
    assign bus_r.in_valid    = in_valid;
    assign bus_r.edge_bit    = edge_bit;
    assign bus_r.gray_data   = gray_data;
    assign bus_r.sram_ready  = sram_ready;

    edge_write_controller #(
        .IMG_W(W), .IMG_H(H), .ADDR_W(AW), .DATA_W(DW), .SERPENTINE(1)
    ) dut_s (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus_s)
    );

    edge_write_controller #(
        .IMG_W(W), .IMG_H(H), .ADDR_W(AW), .DATA_W(DW), .SERPENTINE(0)
    ) dut_r (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus_r)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Address of the k-th pixel of a frame, straight from row/column arithmetic.
    function automatic logic [AW-1:0] paddr(input logic [AW-1:0] b, input int k, input bit serp);
        int row, col, x;
        logic [31:0] s;
        row = k / W;
        col = k % W;
        x   = (serp && (row % 2 == 1)) ? (W - 1 - col) : col;
        s   = 32'(b) + 32'(row * W + x);
        return s[AW-1:0];
    endfunction

    // st: 0 idle, 1 taking pixels, 2 draining last write
    typedef struct packed {
        logic [1:0]    st;
        logic [31:0]   cnt;
        logic          we;
        logic          done;
        logic          gray;
        logic [AW-1:0] base;
        logic [AW-1:0] addr_s;
        logic [AW-1:0] addr_r;
        logic [DW-1:0] data;
    } model_t;

    function automatic model_t step(input model_t m);
        model_t n;
        logic acc;
        n   = m;
        acc = (m.st == 2'd1) && in_valid && (!m.we || sram_ready);
        n.done = 1'b0;
        if (acc) begin
            n.we     = 1'b1;
            n.addr_s = paddr(m.base, int'(m.cnt), 1'b1);
            n.addr_r = paddr(m.base, int'(m.cnt), 1'b0);
            n.data   = m.gray ? gray_data : {DW{edge_bit}};
        end else if (sram_ready) begin
            n.we = 1'b0;
        end
        case (m.st)
            2'd0: if (frame_start && !m.done) begin
                n.st   = 2'd1;
                n.cnt  = 0;
                n.base = base_addr;
                n.gray = gray_mode;
            end
            2'd1: if (acc) begin
                n.cnt = m.cnt + 1;
                if (m.cnt + 1 == N) n.st = 2'd2;
            end
            2'd2: if (!m.we || sram_ready) begin
                n.st   = 2'd0;
                n.done = 1'b1;
            end
            default: ;
        endcase
        return n;
    endfunction

    model_t m = '0;

    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) m <= '0;
        else        m <= step(m);
    end

    always @(posedge clk) cyc <= cyc + 1;

    logic [AW-1:0] wq_s[$];
    logic [AW-1:0] wq_r[$];
    logic [DW-1:0] dq[$];
    int done_cnt = 0;
    int done_cyc = -1;
    int first_we_cyc = -1;
    int last_we_cyc = -1;

    always @(negedge clk) begin
        logic exp_ir;
        exp_ir = (m.st == 2'd1) && (!m.we || sram_ready);
        chk("out_serp",
            {bus_s.in_ready, bus_s.sram_we, bus_s.sram_addr, bus_s.sram_data, bus_s.busy,
             bus_s.frame_done},
            {exp_ir, m.we, m.addr_s, m.data, m.st != 2'd0, m.done});
        chk("out_rast",
            {bus_r.in_ready, bus_r.sram_we, bus_r.sram_addr, bus_r.sram_data, bus_r.busy,
             bus_r.frame_done},
            {exp_ir, m.we, m.addr_r, m.data, m.st != 2'd0, m.done});
        if (bus_s.sram_we && sram_ready) begin
            wq_s.push_back(bus_s.sram_addr);
            dq.push_back(bus_s.sram_data);
            if (first_we_cyc < 0) first_we_cyc = cyc;
            last_we_cyc = cyc;
        end
        if (bus_r.sram_we && sram_ready) wq_r.push_back(bus_r.sram_addr);
        if (bus_s.frame_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        wq_s.delete();
        wq_r.delete();
        dq.delete();
        done_cnt = 0;
        done_cyc = -1;
        first_we_cyc = -1;
        last_we_cyc = -1;
    endtask

    task automatic start_frame(input logic [AW-1:0] b, input logic g);
        clr();
        base_addr   = b;
        gray_mode   = g;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic rand_inputs(input bit hold_valid);
        in_valid    = hold_valid ? 1'b1 : ($urandom % 4 != 0);
        sram_ready  = ($urandom % 4 != 0);
        edge_bit    = 1'($urandom);
        gray_data   = DW'($urandom);
        frame_start = ($urandom % 16 == 0);
        base_addr   = AW'($urandom);
    endtask

    task automatic wait_done(input int budget, input bit rnd, input bit hold_valid);
        int t = 0;
        while (done_cnt == 0 && t < budget) begin
            if (rnd) rand_inputs(hold_valid);
            tick();
            t++;
        end
        frame_start = 1'b0;
        chk("frame_done_seen", logic'(done_cnt != 0), 1'b1);
    endtask

    task automatic check_frame(input string tag, input logic [AW-1:0] b);
        chk({tag, "_nwrites_s"}, 64'(wq_s.size()), 64'(N));
        chk({tag, "_nwrites_r"}, 64'(wq_r.size()), 64'(N));
        for (int k = 0; k < N && k < wq_s.size(); k++)
            chk({tag, "_addr_s"}, wq_s[k], paddr(b, k, 1'b1));
        for (int k = 0; k < N && k < wq_r.size(); k++)
            chk({tag, "_addr_r"}, wq_r[k], paddr(b, k, 1'b0));
        chk({tag, "_done_once"}, 64'(done_cnt), 64'd1);
    endtask

    logic [AW-1:0] exp_serp[12];
    logic [AW-1:0] rb;

    initial begin
        exp_serp = '{'h100, 'h101, 'h102, 'h103, 'h107, 'h106, 'h105, 'h104,
                     'h108, 'h109, 'h10A, 'h10B};
        n_rst = 1'b0;
        repeat (2) tick();
        chk("rst_we", bus_s.sram_we, 1'b0);
        chk("rst_addr", bus_s.sram_addr, '0);
        chk("rst_busy_ready", {bus_s.busy, bus_s.in_ready, bus_s.frame_done}, 3'b000);
        n_rst = 1'b1;
        tick();

        // Gray mode, no stalls; also a start landing on the frame_done cycle.
        in_valid = 1'b1;
        sram_ready = 1'b1;
        gray_data = 8'h5A;
        start_frame(18'h100, 1'b1);
        for (int t = 0; t < 40 && m.st != 2'd2; t++) tick();
        tick();
        chk("done_pulse_lit", bus_s.frame_done, 1'b1);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        chk("start_on_done_ignored", bus_s.busy, 1'b0);
        for (int k = 0; k < 12 && k < wq_s.size(); k++) begin
            chk("t1_serp_lit", wq_s[k], exp_serp[k]);
            chk("t1_rast_lit", wq_r[k], 18'h100 + 18'(k));
            chk("t1_gray_lit", dq[k], 8'h5A);
        end
        chk("t1_back_to_back", 64'(last_we_cyc - first_we_cyc), 64'd11);
        chk("t1_done_latency", 64'(done_cyc), 64'(last_we_cyc + 1));
        check_frame("t1", 18'h100);

        // Edge mode with alternating bits and a three-cycle SRAM stall.
        start_frame(18'h040, 1'b0);
        for (int p = 0; p < 5; p++) begin
            edge_bit = (p % 2 == 0);
            tick();
        end
        sram_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
            tick();
            chk("stall_addr_s", bus_s.sram_addr, 18'h047);
            chk("stall_addr_r", bus_r.sram_addr, 18'h044);
            chk("stall_we_ready", {bus_s.sram_we, bus_s.in_ready}, 2'b10);
        end
        sram_ready = 1'b1;
        for (int p = 5; p < 12; p++) begin
            edge_bit = (p % 2 == 0);
            tick();
        end
        wait_done(20, 1'b0, 1'b0);
        for (int k = 0; k < 12 && k < dq.size(); k++)
            chk("t3_edge_data", dq[k], (k % 2 == 0) ? 8'hFF : 8'h00);
        check_frame("t3", 18'h040);

        // Wrap at top of memory, with an ignored start mid-frame.
        start_frame(18'h3FFFE, 1'b1);
        for (int t = 0; t < 3; t++) begin
            rand_inputs(1'b0);
            frame_start = 1'b0;
            tick();
        end
        base_addr = 18'h12345;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        chk("t4_busy_mid", bus_s.busy, 1'b1);
        wait_done(200, 1'b1, 1'b0);
        if (wq_r.size() >= 4) begin
            chk("t4_wrap0", wq_r[0], 18'h3FFFE);
            chk("t4_wrap1", wq_r[1], 18'h3FFFF);
            chk("t4_wrap2", wq_r[2], 18'h00000);
            chk("t4_wrap3", wq_r[3], 18'h00001);
        end
        check_frame("t4", 18'h3FFFE);

        // Async reset after five pixels, then a clean restart.
        in_valid = 1'b1;
        sram_ready = 1'b1;
        start_frame(18'h100, 1'b0);
        repeat (5) tick();
        n_rst = 1'b0;
        #1;
        chk("rst_mid_s",
            {bus_s.sram_we, bus_s.sram_addr, bus_s.sram_data, bus_s.busy, bus_s.frame_done,
             bus_s.in_ready}, '0);
        chk("rst_mid_r", {bus_r.sram_we, bus_r.sram_addr, bus_r.busy, bus_r.in_ready}, '0);
        tick();
        n_rst = 1'b1;
        tick();
        start_frame(18'h200, 1'b1);
        wait_done(200, 1'b1, 1'b0);
        if (wq_s.size() > 0) chk("t5_restart_addr", wq_s[0], 18'h200);
        check_frame("t5", 18'h200);

        // in_valid held past the last pixel.
        start_frame(18'h1000, 1'b0);
        wait_done(200, 1'b1, 1'b1);
        in_valid = 1'b1;
        frame_start = 1'b0;
        repeat (10) tick();
        check_frame("t6", 18'h1000);

        for (int f = 0; f < 15; f++) begin
            rb = AW'($urandom);
            start_frame(rb, 1'($urandom));
            wait_done(300, 1'b1, 1'b0);
            check_frame("rand", rb);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/edge_write_controller.md
Name: edge_write_controller

Overview:
- Parametrised frame writer at the tail of the edge-detection pipeline.
- Accepts one hysteresis result (or grayscale debug pixel) per handshake.
- Generates the SRAM address for a raster or serpentine scan from a programmable base, and drives a registered SRAM write port with back-pressure.
- Signals frame completion so the top level can trigger a memory dump or the next frame.

Parameters:
- IMG_W, 512, pixels per row (≥2).
- IMG_H, 512, rows per frame (≥1).
- ADDR_W, 18, SRAM address width.
- DATA_W, 8, SRAM data width.
- SERPENTINE, 1, 1 = boustrophedon scan (odd rows right-to-left), 0 = plain raster.

Ports:
- clk  in  1  system clock, rising edge.
- n_rst  in  1  asynchronous active-low reset.
- frame_start  in  1  single-cycle pulse; starts a frame when idle.
- base_addr  in  ADDR_W  frame base address, sampled on accepted frame_start.
- gray_mode  in  1  sampled on accepted frame_start; 1 = write gray_data, 0 = write edge_bit expanded.
- in_valid  in  1  pixel available.
- in_ready  out  1  controller can accept a pixel this cycle.
- edge_bit  in  1  hysteresis result.
- gray_data  in  DATA_W  debug pixel value.
- sram_ready  in  1  SRAM accepts the current write this cycle.
- sram_we  out  1  write request, registered.
- sram_addr  out  ADDR_W  write address, registered.
- sram_data  out  DATA_W  write data, registered.
- busy  out  1  high from accepted frame_start until frame_done.
- frame_done  out  1  single-cycle pulse after the last write completes.

Behaviour:
- Reset values: state IDLE; x, y, dir, pixel count 0; sram_we, sram_addr, sram_data, busy, frame_done, in_ready all 0.
- States:
  - IDLE: frame_start → RUN; clear x/y/dir/count; latch base_addr and gray_mode.
  - RUN: accept pixels until IMG_W*IMG_H have been accepted, then → FLUSH.
  - FLUSH: wait until the output register is empty (sram_we==0, or sram_we & sram_ready) → IDLE, with frame_done pulsed on the cycle of that transition.
- in_ready = (state==RUN) & (!sram_we | sram_ready). Combinational; it never depends on in_valid.
- Accept = in_valid & in_ready. On accept, next cycle:
  - sram_we=1.
  - sram_addr = (base + y*IMG_W + x) mod 2^ADDR_W. Arithmetic is done at ADDR_W+log2 margin and truncated, so it wraps silently.
  - sram_data = gray_mode ? gray_data : {DATA_W{edge_bit}}.
- Output register holds while sram_we & !sram_ready. It clears (sram_we=0) when sram_ready and there is no new accept. Latency from accept to sram_we is 1 cycle, and throughput is 1 pixel/cycle with sram_ready tied high.
- Scan, advanced on accept:
  - dir=0: if x<IMG_W-1 then x++, else y++ and (SERPENTINE ? dir=1 : x=0).
  - dir=1: if x>0 then x--, else y++ and dir=0.
  - Last pixel position: raster → (IMG_W-1, IMG_H-1); serpentine → x = IMG_W-1 if IMG_H is odd, else x = 0.
- Termination is decided by the pixel counter, not by x/y. Extra in_valid after the last accept is not accepted (in_ready=0).
- frame_start while busy: ignored, with no effect on latched base/mode.
- frame_start in the same cycle frame_done pulses: ignored. A new frame requires a start in IDLE on a later cycle.
- Async reset mid-frame: all state and outputs return to reset values immediately, including dropping an in-flight sram_we. No partial-frame recovery.

Decomposition:
- Shared package edge_pkg:
  - state enum {IDLE, RUN, FLUSH}.
  - Default image constants IMG_W_DEF=512, IMG_H_DEF=512.
  - Function clog2-based widths for x/y/count.
- One natural sub-module: scan_addr_gen. It holds the x/y/dir counters, the pixel count, the last flag and the address computation. Its interface is advance, clear, base in; addr and last out.
- The top level holds the FSM, handshake and output register.

Test Plan:
1. IMG_W=4, IMG_H=3, SERPENTINE=1, base=0x100, in_valid and sram_ready held high → 12 writes on consecutive cycles to addresses 100,101,102,103,107,106,105,104,108,109,10A,10B. frame_done pulses exactly 1 cycle after the last sram_we cycle.
2. Same sizes with SERPENTINE=0 → addresses 0x100..0x10B ascending. gray_mode=1 with gray_data=0x5A gives sram_data=0x5A on every write.
3. edge_bit pattern 1,0,1,… with gray_mode=0 → sram_data alternates FF,00. Then sram_ready low for 3 cycles mid-frame → sram_we/addr/data stable, in_ready=0, and no pixel is lost or duplicated.
4. base_addr=0x3FFFE, ADDR_W=18, IMG_W=4 → writes to 3FFFE, 3FFFF, 00000, 00001 (wrap). A frame_start pulse mid-frame is ignored, so busy stays 1 and the base is unchanged.
5. Assert n_rst=0 after pixel 5 of 12 → all outputs 0 within the same cycle. A fresh frame_start then restarts at base with x=y=0.
6. Hold in_valid high past the last pixel → in_ready=0 from the FLUSH entry cycle. Exactly IMG_W*IMG_H writes occur, and frame_done fires once.
